// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers per-digit BCD values from a time-multiplexed 7-segment bus.
// Optional macro SEG7_HEX_DECODE_EN: also accept the A-F hex glyphs as legal digits.
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic [6:0]                                           seg,
   input  logic [NUM_DIGITS-1:0]                                digit_en,
   output logic [4*NUM_DIGITS-1:0]                              digits,
   output logic [NUM_DIGITS-1:0]                                digit_valid,
   output logic                                                 upd_valid,
   output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] upd_idx,
   output logic [3:0]                                           upd_bcd,
   output logic                                                 err_pulse,
   output logic                                                 frame_done
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

   logic [6:0]            seg_q, seg_p;
   logic [NUM_DIGITS-1:0] en_q, en_p;
   logic [CW-1:0]         cnt, cnt_next;
   logic [NUM_DIGITS-1:0] seen, seen_next;
   logic                  en_onehot, changed, commit;
   logic [IW-1:0]         idx;
   logic                  dec_legal, dec_blank;
   logic [3:0]            dec_val;

   // One-hot check and strobe encoding; idx is only meaningful when en_onehot is set.
   always_comb begin
      int hits;
      hits = 0;
      idx  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (en_q[i]) begin
            hits = hits + 1;
            idx  = IW'(i);
         end
      end
      en_onehot = (hits == 1);
   end

   always_comb begin
      changed = ({seg_q, en_q} != {seg_p, en_p});
      if (!en_onehot)
         cnt_next = '0;
      else if (changed)
         cnt_next = CW'(1);
      else if (cnt == CNT_MAX)
         cnt_next = cnt;
      else
         cnt_next = cnt + CW'(1);
      commit    = en_onehot && (cnt_next == CNT_MAX) && (cnt != CNT_MAX);
      seen_next = seen | en_q;
   end

   always_comb begin
      dec_legal = 1'b1;
      dec_blank = 1'b0;
      dec_val   = 4'd0;
      case (seg_q)
         7'b1111110: dec_val = 4'd0;
         7'b0110000: dec_val = 4'd1;
         7'b1101101: dec_val = 4'd2;
         7'b1111001: dec_val = 4'd3;
         7'b0110011: dec_val = 4'd4;
         7'b1011011: dec_val = 4'd5;
         7'b1011111: dec_val = 4'd6;
         7'b1110000: dec_val = 4'd7;
         7'b1111111: dec_val = 4'd8;
         7'b1111011: dec_val = 4'd9;
`ifdef SEG7_HEX_DECODE_EN
         7'b1110111: dec_val = 4'd10;
         7'b0011111: dec_val = 4'd11;
         7'b1001110: dec_val = 4'd12;
         7'b0111101: dec_val = 4'd13;
         7'b1001111: dec_val = 4'd14;
         7'b1000111: dec_val = 4'd15;
`endif
         7'b0000000: begin
            dec_legal = 1'b0;
            dec_blank = 1'b1;
         end
         default:    dec_legal = 1'b0;
      endcase
   end

   // Pulses default low each cycle; a commit also folds the digit into the frame mask.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q       <= '0;
         en_q        <= '0;
         seg_p       <= '0;
         en_p        <= '0;
         cnt         <= '0;
         seen        <= '0;
         digits      <= '0;
         digit_valid <= '0;
         upd_valid   <= 1'b0;
         upd_idx     <= '0;
         upd_bcd     <= 4'd0;
         err_pulse   <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         seg_q      <= seg;
         en_q       <= digit_en;
         seg_p      <= seg_q;
         en_p       <= en_q;
         cnt        <= cnt_next;
         upd_valid  <= 1'b0;
         err_pulse  <= 1'b0;
         frame_done <= 1'b0;
         if (commit) begin
            upd_idx   <= idx;
            upd_bcd   <= dec_legal ? dec_val : 4'd0;
            upd_valid <= dec_legal;
            err_pulse <= !dec_legal && !dec_blank;
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (en_q[i]) begin
                  digit_valid[i] <= dec_legal;
                  if (dec_legal)
                     digits[4*i +: 4] <= dec_val;
               end
            end
            if (seen_next == ALL_SEEN) begin
               frame_done <= 1'b1;
               seen       <= '0;
            end else begin
               seen <= seen_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed-vector self-checking bench for seg7_scan_decoder.
module tb_seg7_scan_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  seg = 7'b0;
   logic [3:0]  digit_en = 4'b0;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        upd_valid;
   logic [1:0]  upd_idx;
   logic [3:0]  upd_bcd;
   logic        err_pulse;
   logic        frame_done;

   int tests = 0;
   int failures = 0;
   int cyc = 0;
   int n_upd = 0;
   int n_err = 0;
   int n_fd = 0;
   int n_fd_idx3 = 0;
   int upd_cyc = 0;
   int start;

   seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .seg(seg), .digit_en(digit_en),
      .digits(digits), .digit_valid(digit_valid), .upd_valid(upd_valid),
      .upd_idx(upd_idx), .upd_bcd(upd_bcd), .err_pulse(err_pulse),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Pulse monitor samples just after each rising edge, clear of the negedge driver.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (upd_valid === 1'b1) begin
         n_upd = n_upd + 1;
         upd_cyc = cyc;
      end
      if (err_pulse === 1'b1)
         n_err = n_err + 1;
      if (frame_done === 1'b1) begin
         n_fd = n_fd + 1;
         if (upd_valid === 1'b1 && upd_idx == 2'd3)
            n_fd_idx3 = n_fd_idx3 + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests = tests + 1;
      if (actual !== expected) begin
         failures = failures + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] s, input logic [3:0] en, input int n);
      seg = s;
      digit_en = en;
      repeat (n) @(negedge clk);
   endtask

   task automatic clearCounts();
      n_upd = 0;
      n_err = 0;
      n_fd = 0;
      n_fd_idx3 = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      clearCounts();

      applyStimulus(7'b0000000, 4'b0000, 20);
      checkOutput("idle_digits", digits, 16'h0000);
      checkOutput("idle_valid", digit_valid, 4'b0000);
      checkOutput("idle_idx", upd_idx, 2'd0);
      checkOutput("idle_bcd", upd_bcd, 4'd0);
      checkOutput("idle_upd", n_upd, 0);
      checkOutput("idle_err", n_err, 0);
      checkOutput("idle_fd", n_fd, 0);

      clearCounts();
      start = cyc;
      applyStimulus(7'b1101101, 4'b0100, 10);
      checkOutput("d2_upd_count", n_upd, 1);
      checkOutput("d2_latency", upd_cyc - start, 5);
      checkOutput("d2_idx", upd_idx, 2'd2);
      checkOutput("d2_bcd", upd_bcd, 4'd2);
      checkOutput("d2_digits", digits, 16'h0200);
      checkOutput("d2_valid", digit_valid, 4'b0100);
      checkOutput("d2_err", n_err, 0);
      applyStimulus(7'b0000000, 4'b0000, 2);

      clearCounts();
      applyStimulus(7'b0110000, 4'b0001, 3);
      applyStimulus(7'b0110000, 4'b0000, 6);
      checkOutput("short_upd", n_upd, 0);
      checkOutput("short_err", n_err, 0);
      checkOutput("short_digits", digits, 16'h0200);
      checkOutput("short_valid", digit_valid, 4'b0100);

      clearCounts();
      applyStimulus(7'b0110000, 4'b0001, 6);
      applyStimulus(7'b0000000, 4'b0000, 1);
      applyStimulus(7'b1101101, 4'b0010, 6);
      applyStimulus(7'b0000000, 4'b0000, 1);
      applyStimulus(7'b1111001, 4'b0100, 6);
      applyStimulus(7'b0000000, 4'b0000, 1);
      applyStimulus(7'b0110011, 4'b1000, 6);
      applyStimulus(7'b0000000, 4'b0000, 1);
      checkOutput("scan_upd", n_upd, 4);
      checkOutput("scan_fd", n_fd, 1);
      checkOutput("scan_fd_idx3", n_fd_idx3, 1);
      checkOutput("scan_digits", digits, 16'h4321);
      checkOutput("scan_valid", digit_valid, 4'b1111);
      checkOutput("scan_idx", upd_idx, 2'd3);
      checkOutput("scan_bcd", upd_bcd, 4'd4);

      clearCounts();
      applyStimulus(7'b1111001, 4'b0010, 6);
      applyStimulus(7'b1000001, 4'b0010, 6);
      applyStimulus(7'b0000000, 4'b0000, 1);
      checkOutput("err_upd", n_upd, 1);
      checkOutput("err_count", n_err, 1);
      checkOutput("err_idx", upd_idx, 2'd1);
      checkOutput("err_bcd", upd_bcd, 4'd0);
      checkOutput("err_valid", digit_valid, 4'b1101);
      checkOutput("err_digits", digits, 16'h4331);
      checkOutput("err_fd", n_fd, 0);

      clearCounts();
      applyStimulus(7'b1001111, 4'b0001, 6);
      applyStimulus(7'b0000000, 4'b0000, 1);
`ifdef SEG7_HEX_DECODE_EN
      checkOutput("hexE_upd", n_upd, 1);
      checkOutput("hexE_err", n_err, 0);
      checkOutput("hexE_bcd", upd_bcd, 4'd14);
      checkOutput("hexE_digits", digits, 16'h433E);
      checkOutput("hexE_valid", digit_valid, 4'b1101);
`else
      checkOutput("hexE_upd", n_upd, 0);
      checkOutput("hexE_err", n_err, 1);
      checkOutput("hexE_bcd", upd_bcd, 4'd0);
      checkOutput("hexE_digits", digits, 16'h4331);
      checkOutput("hexE_valid", digit_valid, 4'b1100);
`endif
      checkOutput("hexE_idx", upd_idx, 2'd0);

      clearCounts();
      applyStimulus(7'b0000000, 4'b0100, 6);
      applyStimulus(7'b0000000, 4'b0000, 1);
      checkOutput("blank_upd", n_upd, 0);
      checkOutput("blank_err", n_err, 0);
      checkOutput("blank_idx", upd_idx, 2'd2);
      checkOutput("blank_bcd", upd_bcd, 4'd0);
`ifdef SEG7_HEX_DECODE_EN
      checkOutput("blank_valid", digit_valid, 4'b1001);
`else
      checkOutput("blank_valid", digit_valid, 4'b1000);
`endif

      clearCounts();
      applyStimulus(7'b1111111, 4'b0110, 8);
      applyStimulus(7'b0000000, 4'b0000, 1);
      checkOutput("multi_upd", n_upd, 0);
      checkOutput("multi_err", n_err, 0);
      checkOutput("multi_idx", upd_idx, 2'd2);

      // Reset lands when the dwell counter has reached 3.
      clearCounts();
      applyStimulus(7'b1111111, 4'b0010, 4);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rst_digits", digits, 16'h0000);
      checkOutput("rst_valid", digit_valid, 4'b0000);
      checkOutput("rst_idx", upd_idx, 2'd0);
      checkOutput("rst_upd", n_upd, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_no_pulse", n_upd + n_err + n_fd, 0);
      repeat (5) @(negedge clk);
      checkOutput("rst_recommit", n_upd, 1);
      checkOutput("rst_re_idx", upd_idx, 2'd1);
      checkOutput("rst_re_bcd", upd_bcd, 4'd8);
      checkOutput("rst_re_digits", digits, 16'h0080);
      checkOutput("rst_re_valid", digit_valid, 4'b0010);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reads back a time-multiplexed 7-segment display bus (segment lines plus one-hot digit strobes) and reconstructs the BCD value of each digit.
- Acts as the reverse of the BCD-to-7-segment driver: used as an on-chip display monitor and as a self-check / loopback checker for the display path.
- Filters scan transitions and ghosting with a stability counter, then commits decoded digits with a one-cycle update pulse.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; width of the strobe bus.
- STABLE_CYCLES, 4, consecutive identical registered samples required before a commit; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- seg  input  7  segment lines {a,b,c,d,e,f,g}; seg[6]=a; 1 = lit.
- digit_en  input  NUM_DIGITS  digit strobes, active high, one-hot while a digit is driven.
- digits  output  4*NUM_DIGITS  captured BCD values; digit i at [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i = digits slice i holds a valid decode.
- upd_valid  output  1  one-cycle pulse: a valid digit was committed.
- upd_idx  output  $clog2(NUM_DIGITS) (min 1)  index of the committed, erroring or blank digit.
- upd_bcd  output  4  decoded value for that commit.
- err_pulse  output  1  one-cycle pulse: an illegal pattern was committed.
- frame_done  output  1  one-cycle pulse: every digit has been committed since the last frame_done.

Behaviour:
- Reset (rst_n=0 at a rising edge): all outputs, sample registers, counter and seen-mask go to 0.
- Input stage: seg and digit_en are registered every cycle into seg_q and en_q. No other synchroniser is used; inputs are synchronous to clk.
- Stability counter cnt is sized to hold STABLE_CYCLES:
  - en_q not one-hot (all zero or multiple bits set): cnt is cleared to 0 and no commit occurs. This is the blanking interval.
  - en_q one-hot and {seg_q,en_q} differs from the previous registered sample: cnt is loaded with 1.
  - Otherwise cnt increments and saturates at STABLE_CYCLES.
- Commit: happens on the edge where cnt becomes STABLE_CYCLES.
  - Exactly one commit per dwell; no re-commit while the inputs are held.
  - A dwell shorter than STABLE_CYCLES produces no commit.
- Latency: if the inputs are stable from the edge at cycle 0, the pulse outputs are high during the cycle following edge STABLE_CYCLES.
- Decode table ({a..g} -> value): 1111110 -> 0, 0110000 -> 1, 1101101 -> 2, 1111001 -> 3, 0110011 -> 4, 1011011 -> 5, 1011111 -> 6, 1110000 -> 7, 1111111 -> 8, 1111011 -> 9.
- Commit of a legal pattern:
  - digits slice updated and digit_valid[i] set.
  - upd_valid=1, upd_idx=i, upd_bcd=value.
- Commit of the blank pattern (0000000):
  - digits slice unchanged, digit_valid[i] cleared.
  - No upd_valid and no err_pulse.
  - upd_idx=i, upd_bcd=0.
- Commit of any other pattern:
  - digits slice unchanged, digit_valid[i] cleared.
  - err_pulse=1, upd_idx=i, upd_bcd=0.
- upd_idx and upd_bcd hold their last value when no commit occurs.
- Frame tracking:
  - Every commit (legal, blank or error) sets seen[i].
  - When a commit completes an all-ones mask, frame_done pulses in the same cycle as the commit pulse and seen is cleared on that edge.
  - A repeat commit of an already-seen digit does not pulse frame_done.
- Reset mid-dwell: counter, mask and outputs clear; capture restarts from a fresh sample.

Optional Feature:
- Macro: SEG7_HEX_DECODE_EN.
- Defined: these patterns decode as legal values 10-15 with upd_valid:
  - 1110111 -> A (10)
  - 0011111 -> b (11)
  - 1001110 -> C (12)
  - 0111101 -> d (13)
  - 1001111 -> E (14)
  - 1000111 -> F (15)
- Not defined: those patterns take the error path (err_pulse=1, digit_valid bit cleared).

Test Plan:
- Reset then idle with digit_en=0000 -> all outputs 0, no pulses for 20 cycles.
- seg=1101101, digit_en=0100 held 10 cycles -> single upd_valid after edge 4, upd_idx=2, upd_bcd=2, digits[11:8]=2, digit_valid=0100.
- seg=0110000, digit_en=0001 held 3 cycles, then digit_en=0000 -> no upd_valid, no err_pulse, digits unchanged.
- Scan digits 0..3 with 1,2,3,4, 6 cycles each with 1 blank cycle between -> four upd_valid pulses; frame_done coincides with the idx=3 commit; digits=16'h4321, digit_valid=1111.
- Digit 1 holds 3, then seg=1000001 for 6 cycles -> err_pulse with upd_idx=1, digit_valid[1]=0, digits[7:4] stays 3.
  - With SEG7_HEX_DECODE_EN, seg=1001111 on digit 0 -> upd_valid with upd_bcd=14.
- digit_en=0110 with seg=1111111 for 8 cycles -> no commit. rst_n=0 asserted while cnt=3 -> everything cleared and no pulse afterwards.
